// File: rtl/mont_pkg.sv
// mont_pkg: shared FSM state type and default operand width for the Montgomery multiplier.
package mont_pkg;
    typedef enum logic [1:0] {IDLE, CALC, SUB} state_t;
    localparam int W_DEF = 256;
endpackage

// File: rtl/mont_step.sv
// mont_step: one radix-2 Montgomery step, o_v = (i_v + i_a*i_b [+ i_n if odd]) / 2, carries kept exactly.
module mont_step #(
    parameter int W = 256
) (
    input  logic [W+1:0] i_v,
    input  logic         i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_n,
    output logic [W+1:0] o_v
);
    logic [W+2:0] w_t, w_u;
    assign w_t = {1'b0, i_v} + (i_a ? {3'b000, i_b} : '0);
    assign w_u = w_t + (w_t[0] ? {3'b000, i_n} : '0);
    assign o_v = w_u[W+2:1];
endmodule

// File: rtl/mont_mult.sv
// mont_mult: iterative Montgomery multiplier, V_o = A*B*2^-W mod N.
// Define MONT_RADIX4_EN to cascade two steps per cycle (W/2 CALC cycles, same results).
module mont_mult
    import mont_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] N_i,
    input  logic [W-1:0] A_i,
    input  logic [W-1:0] B_i,
    output logic [W-1:0] V_o,
    output logic         finish_o,
    output logic         busy_o
);
    localparam int CW = $clog2(W) + 1;
`ifdef MONT_RADIX4_EN
    localparam int SH = 2;
`else
    localparam int SH = 1;
`endif
    localparam logic [CW-1:0] LAST = CW'(W / SH - 1);

    state_t         r_state, w_next;
    logic [W-1:0]   r_a, r_b, r_n;
    logic [W+1:0]   r_v, w_v1, w_vn;
    logic [CW-1:0]  r_cnt;

    mont_step #(.W(W)) u_step0 (.i_v(r_v), .i_a(r_a[0]), .i_b(r_b), .i_n(r_n), .o_v(w_v1));
`ifdef MONT_RADIX4_EN
    mont_step #(.W(W)) u_step1 (.i_v(w_v1), .i_a(r_a[1]), .i_b(r_b), .i_n(r_n), .o_v(w_vn));
`else
    assign w_vn = w_v1;
`endif

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE) ? (start_i ? CALC : IDLE) :
                 (r_state == CALC) ? ((r_cnt == LAST) ? SUB : CALC) : IDLE;
    end

    assign busy_o = (r_state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_v      <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            V_o      <= '0;
            finish_o <= 1'b0;
        end else begin
            r_state  <= w_next;
            finish_o <= (r_state == SUB);
            if (r_state == IDLE && start_i) begin
                r_a   <= A_i;
                r_b   <= B_i;
                r_n   <= N_i;
                r_v   <= '0;
                r_cnt <= '0;
            end else if (r_state == CALC) begin
                // multiplicand is consumed LSB first by shifting it down
                r_a   <= r_a >> SH;
                r_v   <= w_vn;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == SUB)
                V_o <= (r_v >= {2'b00, r_n}) ? r_v[W-1:0] - r_n : r_v[W-1:0];
        end
    end
endmodule

// File: doc/mont_mult.md
MONT_MULT -- requirements
Module: mont_mult

Interface
REQ-001 SHALL have parameter W, default 256: operand/modulus width in bits; legal values even, W >= 4.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port N_i  input  W  modulus; odd, captured at start.
REQ-006 SHALL have port A_i  input  W  multiplicand; less than N_i, captured at start.
REQ-007 SHALL have port B_i  input  W  multiplier; less than N_i, captured at start.
REQ-008 SHALL have port V_o  output  W  result A*B*2^-W mod N; registered.
REQ-009 SHALL have port finish_o  output  1  one-cycle pulse, V_o valid.
REQ-010 SHALL have port busy_o  output  1  high in CALC and SUB.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, SUB; IDLE->CALC on start_i=1; CALC->SUB after last iteration; SUB->IDLE unconditionally.
REQ-012 SHALL, on the IDLE->CALC edge, register A_i, B_i, N_i, clear accumulator V (W+2 bits) and clear iteration counter.
REQ-013 SHALL, per radix-2 step i (LSB first): t = V + A[i]*B; if t odd, t = t + N; V = t >> 1 (exact, no truncation of carries).
REQ-014 SHALL perform one step per CALC cycle; CALC lasts exactly W cycles in radix-2 mode.
REQ-015 SHALL, in SUB, write V_o = (V >= N) ? V - N : V, truncated to W bits, and assert finish_o for exactly that one cycle.
REQ-016 SHALL give latency W+1 cycles: start sampled at edge k -> V_o updated and finish_o high after edge k+W+1.
REQ-017 SHALL hold V_o stable from finish until the next SUB write; new start SHALL NOT clear V_o.
REQ-018 SHALL ignore start_i while busy_o=1; operands changing mid-operation SHALL have no effect.
REQ-019 SHALL accept start_i in the cycle finish_o is high (state IDLE): back-to-back operations with no gap.
REQ-020 SHALL guarantee V < 2N at every step for legal inputs; behaviour for even N or A,B >= N is unspecified but SHALL still terminate in W+1 cycles.

Reset
REQ-021 SHALL, when rst_i=1 at a clock edge, force state IDLE, V_o=0, finish_o=0, busy_o=0, accumulator and counter 0.
REQ-022 SHALL allow reset at any point, including mid-CALC and in SUB; an aborted operation SHALL produce no finish_o pulse.
REQ-023 SHALL give rst_i priority over start_i in the same cycle.

Configuration
REQ-024 SHALL support macro MONT_RADIX4_EN.
REQ-025 SHALL, with MONT_RADIX4_EN defined, perform two cascaded radix-2 steps (bits 2j, 2j+1) per CALC cycle: CALC lasts W/2 cycles, latency W/2+1, results bit-identical to radix-2.
REQ-026 SHALL, without MONT_RADIX4_EN, perform one step per cycle as in REQ-014/016.

Structure
REQ-027 SHALL place FSM state enum type and default width constant in shared package mont_pkg.
REQ-028 SHALL implement one step (REQ-013) as sub-module mont_step (combinational, parameter W), instantiated once, or twice under MONT_RADIX4_EN.
REQ-029 SHALL keep counter width $clog2(W)+1.

Verification
REQ-030 SHALL cover: W=8, N=13, A=5, B=7 -> V_o=1, finish_o after 9 cycles (5 with MONT_RADIX4_EN).
REQ-031 SHALL cover: W=8, N=13, A=12, B=12 -> V_o=3; A=1, B=1 -> V_o=3; A=0, B=9 -> V_o=0.
REQ-032 SHALL cover: W=256, 1000 random odd N, A,B < N, back-to-back starts -> V_o matches reference model A*B*2^-256 mod N each time, finish_o one cycle wide.
REQ-033 SHALL cover: start_i pulsed and operands changed during CALC -> result of first operands only, latency unchanged.
REQ-034 SHALL cover: rst_i asserted at CALC cycle 3 -> next cycle busy_o=0, V_o=0, no finish_o; subsequent start completes correctly.
REQ-035 SHALL cover: rst_i and start_i high same cycle -> remains IDLE, busy_o=0.
